// File: rtl/leaky_relu_stream.sv
// Streaming leaky-ReLU over CH signed lanes with a two-register, backpressured
// pipeline and a saturating counter of negative lanes accepted.
module leaky_relu_stream #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CH        = 4,
    parameter int unsigned SHIFT_MAX = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                                                      clk,
    input  logic                                                      rst_n,
    input  logic [1:0]                                                mode,
    input  logic [((SHIFT_MAX > 0) ? $clog2(SHIFT_MAX + 1) : 1)-1:0] alpha_shift,
    input  logic                                                      in_valid,
    output logic                                                      in_ready,
    input  logic [CH*DATA_W-1:0]                                      in_data,
    input  logic                                                      in_last,
    output logic                                                      out_valid,
    input  logic                                                      out_ready,
    output logic [CH*2*DATA_W-1:0]                                    out_data,
    output logic                                                      out_last,
    input  logic                                                      cnt_clr,
    output logic [CNT_W-1:0]                                          neg_count
);

    localparam int unsigned OUT_W = 2 * DATA_W;
    localparam int unsigned SHW   = (SHIFT_MAX > 0) ? $clog2(SHIFT_MAX + 1) : 1;
    localparam int unsigned NW    = $clog2(CH + 1);
    localparam int unsigned SUM_W = ((CNT_W > NW) ? CNT_W : NW) + 1;

    localparam logic [1:0] MODE_RELU   = 2'b01;
    localparam logic [1:0] MODE_BYPASS = 2'b10;

    logic                  advance;
    logic                  accept;
    logic [SHW-1:0]        shift_clamped;

    logic                  s1_valid;
    logic [CH*DATA_W-1:0]  s1_data;
    logic                  s1_last;
    logic [1:0]            s1_mode;
    logic [SHW-1:0]        s1_shift;

    logic [CH*OUT_W-1:0]   lane_result;
    logic [SHW-1:0]        leak_amt;
    logic [DATA_W-1:0]     lane_x;
    logic [OUT_W-1:0]      lane_ext;
    logic [OUT_W-1:0]      lane_y;

    logic [NW-1:0]         neg_lanes;
    logic [SUM_W-1:0]      cnt_sum;
    logic [CNT_W-1:0]      cnt_next;

    // Both stages move together whenever the output register can take a beat.
    assign in_ready = !out_valid || out_ready;
    assign advance  = in_ready;
    assign accept   = in_valid && in_ready;

    assign shift_clamped = (alpha_shift > SHW'(SHIFT_MAX)) ? SHW'(SHIFT_MAX) : alpha_shift;

    // Stage 1: capture the beat together with its per-beat mode and slope.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_last  <= 1'b0;
            s1_mode  <= '0;
            s1_shift <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_data  <= in_data;
            s1_last  <= in_last;
            s1_mode  <= mode;
            s1_shift <= shift_clamped;
        end
    end

    // Per-lane activation: positive lanes and bypass scale by 2^SHIFT_MAX,
    // negative leaky lanes scale by 2^(SHIFT_MAX-s); OUT_W leaves headroom.
    always_comb begin
        lane_result = '0;
        lane_x      = '0;
        lane_ext    = '0;
        lane_y      = '0;
        leak_amt    = SHW'(SHIFT_MAX) - s1_shift;
        for (int k = 0; k < int'(CH); k++) begin
            lane_x   = s1_data[k*DATA_W +: DATA_W];
            lane_ext = {{DATA_W{lane_x[DATA_W-1]}}, lane_x};
            lane_y   = lane_ext << SHIFT_MAX;
            if (lane_x[DATA_W-1]) begin
                case (s1_mode)
                    MODE_RELU:   lane_y = '0;
                    MODE_BYPASS: lane_y = lane_ext << SHIFT_MAX;
                    default:     lane_y = lane_ext << leak_amt;
                endcase
            end
            lane_result[k*OUT_W +: OUT_W] = lane_y;
        end
    end

    // Stage 2: output register, held stable while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            out_data  <= lane_result;
            out_last  <= s1_last;
        end
    end

    // Negative-lane count of the incoming beat and saturating next counter value.
    always_comb begin
        neg_lanes = '0;
        for (int k = 0; k < int'(CH); k++) begin
            neg_lanes = neg_lanes + NW'(in_data[k*DATA_W + DATA_W - 1]);
        end
        cnt_sum  = (cnt_clr ? SUM_W'(0) : SUM_W'(neg_count))
                 + (accept ? SUM_W'(neg_lanes) : SUM_W'(0));
        cnt_next = (cnt_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : CNT_W'(cnt_sum);
    end

    // Counter update; a clear together with an acceptance loads that beat's count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_count <= '0;
        end else if (accept || cnt_clr) begin
            neg_count <= cnt_next;
        end
    end

endmodule

// File: tb/tb_leaky_relu_stream.sv
// Scoreboard bench for leaky_relu_stream: expectations are queued at acceptance
// and compared at delivery; a second instance with a 4-bit counter shares stimulus.
module tb_leaky_relu_stream;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned CH        = 4;
    localparam int unsigned SHIFT_MAX = 4;
    localparam int unsigned OUT_W     = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic [2:0]  alpha_shift;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        cnt_clr;
    logic [15:0] neg_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [63:0] out_data4;
    logic        out_last4;
    logic [3:0]  neg_count4;

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   m16      = 0;
    int   m4       = 0;
    bit   lat_next = 1'b0;
    bit   drv_done = 1'b0;

    leaky_relu_stream #(.DATA_W(DATA_W), .CH(CH), .SHIFT_MAX(SHIFT_MAX), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .alpha_shift(alpha_shift),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .cnt_clr(cnt_clr), .neg_count(neg_count)
    );

    leaky_relu_stream #(.DATA_W(DATA_W), .CH(CH), .SHIFT_MAX(SHIFT_MAX), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .alpha_shift(alpha_shift),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_last(out_last4),
        .cnt_clr(cnt_clr), .neg_count(neg_count4)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if the values differ.
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference activation computed with integer arithmetic.
    function automatic logic [63:0] model(input logic [31:0] d, input logic [1:0] m,
                                          input logic [2:0] s);
        logic [63:0] r;
        logic [7:0]  lane;
        int          x;
        int          y;
        int          sc;
        r  = '0;
        sc = (int'(s) > 4) ? 4 : int'(s);
        for (int k = 0; k < 4; k++) begin
            lane = d[k*8 +: 8];
            x    = int'($signed(lane));
            if (x >= 0)       y = x * 16;
            else if (m == 2'b01) y = 0;
            else if (m == 2'b10) y = x * 16;
            else              y = x * (1 << (4 - sc));
            r[k*16 +: 16] = 16'(y);
        end
        return r;
    endfunction

    function automatic int negs(input logic [31:0] d);
        int n;
        n = 0;
        for (int k = 0; k < 4; k++) n += int'(d[k*8 + 7]);
        return n;
    endfunction

    // Monitor: sampled on the falling edge, halfway between active edges.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            sb.delete();
            m16 = 0;
            m4  = 0;
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_data", out_data, 64'd0);
            check("rst_out_last", 64'(out_last), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_neg_count", 64'(neg_count), 64'd0);
        end else begin
            check("neg_count", 64'(neg_count), 64'(m16));
            check("neg_count4", 64'(neg_count4), 64'(m4));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("beat_expected", 64'(sb.size()), 64'd1);
                end else if (out_ready) begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", 64'(out_last), 64'(e.last));
                    if (e.lat) check("latency", 64'(cyc - e.acc), 64'd2);
                end else begin
                    check("stall_data", out_data, sb[0].data);
                    check("stall_last", 64'(out_last), 64'(sb[0].last));
                end
            end
            if (in_valid && in_ready) begin
                e.data = model(in_data, mode, alpha_shift);
                e.last = in_last;
                e.acc  = cyc;
                e.lat  = lat_next;
                sb.push_back(e);
            end
            if (cnt_clr) begin
                m16 = 0;
                m4  = 0;
            end
            if (in_valid && in_ready) begin
                m16 += negs(in_data);
                m4  += negs(in_data);
            end
            if (m16 > 65535) m16 = 65535;
            if (m4 > 15) m4 = 15;
        end
    end

    // Drive one beat from just after a rising edge until it is accepted.
    task automatic send(input logic [31:0] d, input logic l, input logic [1:0] m,
                        input logic [2:0] s, input bit clr, input bit lat);
        int tries;
        in_data     = d;
        in_last     = l;
        mode        = m;
        alpha_shift = s;
        cnt_clr     = clr;
        lat_next    = lat;
        in_valid    = 1'b1;
        tries       = 0;
        @(negedge clk);
        while (!in_ready && tries < 200) begin
            tries++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        lat_next = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        mode        = 2'b00;
        alpha_shift = 3'd4;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        out_ready   = 1'b1;
        cnt_clr     = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Basic leaky beat with latency measurement, then the single-lane corner values.
        send(32'h7F00_F005, 1'b1, 2'b00, 3'd4, 1'b0, 1'b1);
        idle(3);
        send(32'h1200_F034, 1'b0, 2'b00, 3'd2, 1'b0, 1'b1);
        send(32'h00F0_0101, 1'b0, 2'b00, 3'd7, 1'b0, 1'b1);
        send(32'h7F80_7F80, 1'b0, 2'b01, 3'd0, 1'b0, 1'b1);
        send(32'h8001_7F80, 1'b1, 2'b10, 3'd1, 1'b0, 1'b1);
        send(32'hC0A0_9080, 1'b0, 2'b11, 3'd3, 1'b0, 1'b1);
        idle(4);

        // Backpressure: pipeline fills, in_ready drops, output held stable.
        out_ready = 1'b0;
        fork
            begin
                send(32'h8112_F3E4, 1'b0, 2'b00, 3'd1, 1'b0, 1'b0);
                send(32'h0506_0708, 1'b0, 2'b01, 3'd2, 1'b0, 1'b0);
                send(32'hFF7F_8001, 1'b1, 2'b10, 3'd3, 1'b0, 1'b0);
            end
            begin
                repeat (7) @(negedge clk);
                check("in_ready_full", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);

        // Mode switch between consecutive beats.
        send(32'hFFFF_FFFF, 1'b0, 2'b00, 3'd4, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, 1'b1, 2'b01, 3'd4, 1'b0, 1'b1);
        idle(4);

        // Random traffic with random sink stalls and occasional clears.
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    send($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                         3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), 1'b0);
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        idle(4);

        // Reset with two beats in flight, then a fresh beat.
        send(32'h8080_8080, 1'b0, 2'b00, 3'd1, 1'b0, 1'b0);
        send(32'h9090_0101, 1'b1, 2'b01, 3'd2, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_neg_count", 64'(neg_count), 64'd0);
        idle(2);
        rst_n = 1'b1;
        send(32'h11F2_33C4, 1'b1, 2'b00, 3'd3, 1'b0, 1'b1);
        idle(4);

        // Counter saturation on the 4-bit instance and clear-with-beat load.
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h8080_8080, 1'b0, 2'b00, 3'd4, 1'b0, 1'b0);
        idle(1);
        check("sat_neg_count4", 64'(neg_count4), 64'd15);
        check("nosat_neg_count", 64'(neg_count), 64'd16);
        send(32'hFFFE_8081, 1'b1, 2'b01, 3'd0, 1'b1, 1'b0);
        idle(1);
        check("clr_load_count4", 64'(neg_count4), 64'd4);
        check("clr_load_count", 64'(neg_count), 64'd4);

        // Drain remaining beats.
        out_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) idle(1);
        check("drain_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/leaky_relu_stream.md
LEAKY_RELU_STREAM -- requirements
Module: leaky_relu_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed input element width.
REQ-002 SHALL have parameter CH, default 4, lanes processed per beat.
REQ-003 SHALL have parameter SHIFT_MAX, default 4, output fractional bits and maximum alpha shift; legal range 0..DATA_W.
REQ-004 SHALL have parameter CNT_W, default 16, negative-element counter width.
REQ-005 SHALL derive localparams OUT_W = 2*DATA_W and SHW = clog2(SHIFT_MAX+1).
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 mode  in  2  00 leaky, 01 relu, 10 bypass, 11 treated as leaky.
REQ-009 alpha_shift  in  SHW  negative slope = 2^-alpha_shift; values above SHIFT_MAX treated as SHIFT_MAX.
REQ-010 in_valid / in_ready  in / out  1 each  input handshake.
REQ-011 in_data  in  CH*DATA_W  lane k at bits [k*DATA_W +: DATA_W], two's complement.
REQ-012 in_last  in  1  frame marker, carried with the beat.
REQ-013 out_valid / out_ready  out / in  1 each  output handshake.
REQ-014 out_data  out  CH*OUT_W  lane k at bits [k*OUT_W +: OUT_W], two's complement, SHIFT_MAX fractional bits.
REQ-015 out_last  out  1  in_last of the presented beat.
REQ-016 cnt_clr  in  1  synchronous clear of neg_count.
REQ-017 neg_count  out  CNT_W  saturating count of negative lanes accepted.

Function
REQ-018 Per lane, x signed DATA_W, result y SHALL be: x >= 0 -> x*2^SHIFT_MAX; x < 0 in leaky -> x*2^(SHIFT_MAX-s), s = clamped alpha_shift; x < 0 in relu -> 0; bypass -> x*2^SHIFT_MAX for all x; always sign-extended to OUT_W, never overflowing.
REQ-019 Two-register pipeline: stage 1 captures in_data, in_last, mode and the clamped shift; stage 2 holds the computed result; latency from acceptance to out_valid SHALL be exactly 2 cycles with out_ready held high.
REQ-020 A beat is accepted iff in_valid && in_ready; a beat is delivered iff out_valid && out_ready.
REQ-021 in_ready SHALL equal (!out_valid || out_ready) combinationally; both stages advance together under that enable and hold otherwise.
REQ-022 While out_valid && !out_ready, out_data and out_last SHALL remain stable.
REQ-023 Throughput SHALL be one beat per cycle with no bubbles while in_valid and out_ready stay high.
REQ-024 mode/alpha_shift SHALL be sampled per beat at acceptance; changes affect only later-accepted beats.
REQ-025 Beats SHALL leave in acceptance order; none dropped or duplicated.
REQ-026 neg_count SHALL add the number of lanes with sign bit 1 on each accepted beat, in every mode; zero is not negative.
REQ-027 neg_count SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-028 cnt_clr with a simultaneous acceptance SHALL load that beat's negative-lane count; cnt_clr alone loads 0.

Reset
REQ-029 While rst_n is low: out_valid = 0, both stage-valid flags = 0, out_data = 0, out_last = 0, neg_count = 0.
REQ-030 Reset mid-stream SHALL discard all in-flight beats; the first beat accepted after release appears 2 cycles later.
REQ-031 in_ready SHALL be 1 during and immediately after reset (follows from out_valid = 0).

Verification (DATA_W=8, CH=4, SHIFT_MAX=4)
REQ-032 Leaky, shift 4, lanes {05,F0,00,7F} -> out {0050,FFF0,0000,07F0} exactly 2 cycles after acceptance; neg_count +1.
REQ-033 Leaky shift 2 lane F0 -> FFC0; shift 7 (clamped) F0 -> FFF0; relu 80 -> 0000, 7F -> 07F0; bypass 80 -> F800.
REQ-034 Accept 3 beats, drop out_ready 5 cycles: in_ready low once pipeline full, out_data stable, all 3 beats delivered in order after release.
REQ-035 Toggle mode leaky->relu between consecutive beats both carrying lane FF: first -> FFFF, second -> 0000.
REQ-036 Assert rst_n low with 2 beats in flight: out_valid 0 immediately, neg_count 0; new beat delivered 2 cycles after acceptance.
REQ-037 CNT_W=4: 4 beats all-negative -> neg_count 15 (saturated); cnt_clr with all-negative beat -> 4.
